display_mode_controller: RTL and testbench

Frame-synchronous controller that owns the OLED pixel stream and the 7-segment display in the top level. It chooses which of `NUM_SRC` pixel generators (graphical visualisation, snake game, …) drives `oled_data`. It steps the selection on a debounced button press, and commits a change only at a frame boundary so a frame never mixes sources. It also scans the 4-digit 7-segment display to show the active mode number.

---
 rtl/display_mode_controller.sv | 143 ++++++++++++++
 tb/tb_display_mode_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_controller.sv
// Frame-synchronous OLED source selector with debounced mode stepping and 7-seg mode readout.
// Latency: fb_rise 3 clk after frame_begin, mode +1 clk, oled_data +1 clk; no backpressure, pixels stream every clock.
module display_mode_controller #(
  parameter int NUM_SRC         = 4,
  parameter int RESET_MODE      = 0,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 100_000,
  parameter int BLANK_FRAMES    = 1
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset_n,
  input  logic                   btn_next,
  input  logic                   frame_begin,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [16*NUM_SRC-1:0]  src_data,
  output logic [15:0]            oled_data,
  output logic [1:0]             mode,
  output logic                   mode_pending,
  output logic                   switch_pulse,
  output logic                   no_source,
  output logic [3:0]             an,
  output logic [7:0]             seg
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  logic          btn_s1, btn_s2, btn_deb, btn_deb_q;
  logic [DW-1:0] deb_cnt;
  logic          fb_s1, fb_s2, fb_s2_q, fb_rise;
  logic [BW-1:0] blank_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    slot;

  logic [3:0]    valid4;
  logic [1:0]    nxt, idx;
  logic          nxt_found, any_valid, btn_rise, do_switch;
  logic [15:0]   sel_pix;
  logic [7:0]    digit;

  assign valid4    = 4'(src_valid);
  assign any_valid = |src_valid;
  assign btn_rise  = btn_deb & ~btn_deb_q;
  assign do_switch = fb_rise & any_valid & nxt_found & (mode_pending | ~valid4[mode]);

  // Walk downward so the nearest valid index after mode is the one that sticks.
  always_comb begin
    nxt       = mode;
    nxt_found = 1'b0;
    idx       = '0;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      idx = 2'((int'(mode) + k) % NUM_SRC);
      if (valid4[idx]) begin
        nxt       = idx;
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_pix = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode == 2'(i)) sel_pix = src_data[16*i +: 16];
    end
  end

  always_comb begin
    digit = 8'hFF;
    unique case (mode)
      2'd0: digit = 8'hC0;
      2'd1: digit = 8'hF9;
      2'd2: digit = 8'hA4;
      2'd3: digit = 8'hB0;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_deb      <= 1'b0;
      btn_deb_q    <= 1'b0;
      deb_cnt      <= '0;
      fb_s1        <= 1'b0;
      fb_s2        <= 1'b0;
      fb_s2_q      <= 1'b0;
      fb_rise      <= 1'b0;
      mode         <= 2'(RESET_MODE);
      mode_pending <= 1'b0;
      switch_pulse <= 1'b0;
      no_source    <= 1'b0;
      blank_cnt    <= '0;
      oled_data    <= 16'h0000;
      scan_cnt     <= '0;
      slot         <= 2'd0;
      an           <= 4'b1111;
      seg          <= 8'hFF;
    end else begin
      btn_s1    <= btn_next;
      btn_s2    <= btn_s1;
      btn_deb_q <= btn_deb;
      if (btn_s2 != btn_deb) begin
        if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_deb <= btn_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end

      fb_s1   <= frame_begin;
      fb_s2   <= fb_s1;
      fb_s2_q <= fb_s2;
      fb_rise <= fb_s2 & ~fb_s2_q;

      // A press arriving while a request is outstanding is dropped.
      if (fb_rise && mode_pending) mode_pending <= 1'b0;
      else if (btn_rise)           mode_pending <= 1'b1;

      switch_pulse <= do_switch;
      if (do_switch) mode <= nxt;
      if (fb_rise) no_source <= ~any_valid;

      if (do_switch)                      blank_cnt <= BW'(BLANK_FRAMES);
      else if (fb_rise && blank_cnt != 0) blank_cnt <= blank_cnt - BW'(1);

      oled_data <= (blank_cnt != 0 || no_source) ? 16'h0000 : sel_pix;

      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        slot     <= slot + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      an  <= ~(4'b0001 << slot);
      seg <= (slot != 2'd0) ? 8'hFF : (no_source ? 8'hBF : digit);
    end
  end

endmodule

// File: tb/tb_display_mode_controller.sv
// Randomized bench for display_mode_controller with an event-level model of mode/pending/blanking.
module tb_display_mode_controller;

  localparam int NUM_SRC = 4;
  localparam int DEB     = 4;
  localparam int SCAN    = 4;
  localparam int BLANK   = 1;

  logic        CLK100MHZ = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_next = 1'b0;
  logic        frame_begin = 1'b0;
  logic [3:0]  src_valid = 4'hF;
  logic [15:0] pix [4];
  logic [63:0] src_data;
  logic [15:0] oled_data;
  logic [1:0]  mode;
  logic        mode_pending, switch_pulse, no_source;
  logic [3:0]  an;
  logic [7:0]  seg;

  assign src_data = {pix[3], pix[2], pix[1], pix[0]};

  display_mode_controller #(
    .NUM_SRC(NUM_SRC), .RESET_MODE(0), .DEBOUNCE_CYCLES(DEB),
    .SCAN_DIV(SCAN), .BLANK_FRAMES(BLANK)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .btn_next(btn_next),
    .frame_begin(frame_begin), .src_valid(src_valid), .src_data(src_data),
    .oled_data(oled_data), .mode(mode), .mode_pending(mode_pending),
    .switch_pulse(switch_pulse), .no_source(no_source), .an(an), .seg(seg)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_checks = 0;
  int n_pass   = 0;

  int m_mode, m_blank;
  bit m_pending, m_nosrc, m_sw;
  logic [7:0] digits [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  function automatic bit is_valid(input int idx, input logic [3:0] v);
    return ((v >> idx) & 4'b0001) != 4'b0000;
  endfunction

  function automatic int find_next(input int cur, input logic [3:0] v);
    for (int k = 1; k < NUM_SRC; k++)
      if (is_valid((cur + k) % NUM_SRC, v)) return (cur + k) % NUM_SRC;
    return -1;
  endfunction

  function automatic logic [15:0] exp_pix();
    return (m_blank != 0 || m_nosrc) ? 16'h0000 : pix[m_mode];
  endfunction

  function automatic logic [7:0] exp_digit();
    return m_nosrc ? 8'hBF : digits[m_mode];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_blank = 0; m_pending = 0; m_nosrc = 0; m_sw = 0;
  endtask

  task automatic model_frame(input logic [3:0] v);
    int nxt;
    nxt  = find_next(m_mode, v);
    m_sw = 0;
    if (v == 4'b0000) begin
      m_nosrc = 1;
      if (m_blank > 0) m_blank--;
    end else begin
      m_nosrc = 0;
      if ((m_pending || !is_valid(m_mode, v)) && nxt >= 0) begin
        m_mode  = nxt;
        m_blank = BLANK;
        m_sw    = 1;
      end else if (m_blank > 0) begin
        m_blank--;
      end
    end
    m_pending = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_oled", 32'(oled_data), 32'd0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_pending", 32'(mode_pending), 32'd0);
    check("rst_pulse", 32'(switch_pulse), 32'd0);
    check("rst_nosrc", 32'(no_source), 32'd0);
    reset_n = 1'b1;
    model_reset();
    tick();
    check("rel_an", 32'(an), 32'hE);
    check("rel_seg", 32'(seg), 32'hC0);
  endtask

  task automatic do_press();
    btn_next = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    repeat (8) tick();
    m_pending = 1;
    check("press_pending", 32'(mode_pending), 32'(m_pending));
  endtask

  task automatic do_frame();
    int old_mode;
    old_mode = m_mode;
    model_frame(src_valid);
    frame_begin = 1'b1;
    repeat (3) tick();
    check("mode_hold_at_fb", 32'(mode), 32'(old_mode));
    tick();
    check("mode", 32'(mode), 32'(m_mode));
    check("pulse", 32'(switch_pulse), 32'(m_sw));
    check("pending_clr", 32'(mode_pending), 32'(m_pending));
    check("no_source", 32'(no_source), 32'(m_nosrc));
    frame_begin = 1'b0;
    tick();
    check("pulse_off", 32'(switch_pulse), 32'd0);
    check("oled", 32'(oled_data), 32'(exp_pix()));
    repeat (3) tick();
  endtask

  task automatic check_seg();
    for (int i = 0; i < 4 * SCAN + 2 && an !== 4'b1110; i++) tick();
    check("an_slot0", 32'(an), 32'hE);
    check("seg_slot0", 32'(seg), 32'(exp_digit()));
    repeat (SCAN) tick();
    check("an_slot1", 32'(an), 32'hD);
    check("seg_slot1", 32'(seg), 32'hFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) pix[i] = 16'($urandom);
    model_reset();
    do_reset();

    // Press latency and first commit.
    src_valid = 4'hF;
    btn_next = 1'b1;
    repeat (6) tick();
    check("pending_clk6", 32'(mode_pending), 32'd0);
    tick();
    check("pending_clk7", 32'(mode_pending), 32'd1);
    repeat (3) tick();
    btn_next = 1'b0;
    repeat (8) tick();
    m_pending = 1;
    do_frame();
    do_frame();
    check_seg();

    // Bounce rejection.
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      repeat (2) tick();
    end
    btn_next = 1'b0;
    repeat (10) tick();
    check("bounce_pending", 32'(mode_pending), 32'd0);

    // Skip and wrap.
    src_valid = 4'b1000; do_frame(); do_frame();
    src_valid = 4'b1001; do_press(); do_frame();
    src_valid = 4'b1000; do_frame(); do_frame();
    do_press(); do_frame();

    // Forced switch and no source.
    src_valid = 4'b0100; do_frame();
    src_valid = 4'hF; do_frame();
    src_valid = 4'b1011;
    repeat (4) tick();
    check("mid_frame_mode", 32'(mode), 32'(m_mode));
    check("mid_frame_oled", 32'(oled_data), 32'(exp_pix()));
    do_frame();
    src_valid = 4'b0000; do_frame();
    check_seg();
    src_valid = 4'b0010; do_frame();

    // Request landing on the commit clock waits for the next boundary.
    src_valid = 4'hF; do_frame();
    btn_next = 1'b1;
    repeat (3) tick();
    frame_begin = 1'b1;
    model_frame(src_valid);
    repeat (4) tick();
    m_pending = 1;
    check("same_clk_pending", 32'(mode_pending), 32'd1);
    check("same_clk_mode", 32'(mode), 32'(m_mode));
    check("same_clk_pulse", 32'(switch_pulse), 32'd0);
    repeat (3) tick();
    btn_next = 1'b0;
    frame_begin = 1'b0;
    repeat (8) tick();
    do_frame();

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      src_valid = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) pix[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_press();
      else repeat (2) tick();
      check("rnd_oled_follow", 32'(oled_data), 32'(exp_pix()));
      if ($urandom_range(0, 3) == 0) begin
        src_valid = 4'($urandom_range(0, 15));
        repeat (3) tick();
        check("rnd_mid_mode", 32'(mode), 32'(m_mode));
      end
      do_frame();
      if (it % 8 == 0) check_seg();
    end

    // Reset in the middle of a debounce and a blanking window.
    src_valid = 4'hF;
    do_press();
    do_frame();
    btn_next = 1'b1;
    repeat (3) tick();
    do_reset();
    btn_next = 1'b0;
    repeat (8) tick();
    check("post_rst_pending", 32'(mode_pending), 32'd0);
    do_press();
    do_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
